// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: opcodes, FSM states, ALU ops.
// The opcode helpers keep the ALU-op decode in one place.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_BRZ = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Non-ALU opcodes use SUB so Z reflects operand equality.
    function automatic logic [1:0] alu_decode(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_SUB;
        endcase
    endfunction

endpackage

// File: rtl/pc4.sv
// 4-bit program counter; load beats increment, wraps naturally mod 16.
module pc4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] D,
    output logic [3:0] Q
);

    always_ff @(posedge clk) begin
        if (rst)       Q <= 4'd0;
        else if (load) Q <= D;
        else if (inc)  Q <= Q + 4'd1;
    end

endmodule

// File: rtl/ctrl_seq.sv
// Four-cycle multi-cycle control sequencer (FETCH/DECODE/EXEC/WB) with a halt
// state. All outputs are registered or decoded from state only.
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] INSTR,
    input  logic       Z,
    output logic [3:0] PC,
    output logic [1:0] SEL_A,
    output logic [1:0] SEL_B,
    output logic [1:0] ALU_OP,
    output logic       WR_EN,
    output logic [1:0] WR_SEL,
    output logic       HALT
);

    state_t     state, state_nxt;
    logic [7:0] ir;
    logic       taken;
    logic       pc_inc, pc_load;
    logic [2:0] op;

    assign op   = ir[7:5];
    assign HALT = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (op == OP_HLT) ? S_HALTED : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                state_nxt = S_FETCH;
                pc_load   = (op == OP_JMP) || ((op == OP_BRZ) && taken);
                pc_inc    = !pc_load;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // WR_EN is computed one cycle early so it is a clean registered pulse in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir     <= 8'd0;
            SEL_A  <= 2'd0;
            SEL_B  <= 2'd0;
            ALU_OP <= 2'd0;
            WR_EN  <= 1'b0;
            WR_SEL <= 2'd0;
            taken  <= 1'b0;
        end else begin
            WR_EN <= (state == S_EXEC) && is_alu(op);
            case (state)
                S_FETCH: begin
                    ir    <= INSTR;
                    SEL_A <= INSTR[4:3];
                    SEL_B <= INSTR[2:1];
                end
                S_DECODE: ALU_OP <= alu_decode(op);
                S_EXEC: begin
                    if (is_alu(op)) WR_SEL <= ir[4:3];
                    taken <= (op == OP_BRZ) && Z;
                end
                default: ;
            endcase
        end
    end

    pc4 u_pc (
        .clk  (clk),
        .rst  (rst),
        .inc  (pc_inc),
        .load (pc_load),
        .D    (ir[3:0]),
        .Q    (PC)
    );

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001: clk  input  1  single clock; all state updates on the rising edge.
REQ-002: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003: INSTR  input  8  instruction word from the program ROM at address PC; combinational ROM, valid in the same cycle.
REQ-004: Z  input  1  ALU zero flag for the current SEL_A/SEL_B operands and ALU_OP.
REQ-005: PC  output  4  program counter, ROM address.
REQ-006: SEL_A  output  2  register-file read select A; also the destination register.
REQ-007: SEL_B  output  2  register-file read select B.
REQ-008: ALU_OP  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009: WR_EN  output  1  register-file write enable, one-cycle pulse.
REQ-010: WR_SEL  output  2  register-file write address.
REQ-011: HALT  output  1  high while the sequencer is halted.

Function
REQ-012: Instruction format SHALL be [7:5] opcode, [4:3] rd, [2:1] rs, [0] unused; for JMP/BRZ, [3:0] is the target.
REQ-013: Opcodes SHALL be 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 JMP, 110 BRZ, 111 HLT.
REQ-014: The FSM SHALL use states FETCH, DECODE, EXEC, WB and HALTED; the sequence is FETCH->DECODE->EXEC->WB->FETCH, one cycle per state, so each instruction takes 4 cycles.
REQ-015: FETCH SHALL load INSTR into a private instruction register IR at the end of the cycle.
REQ-016: From DECODE through WB, SEL_A SHALL equal IR[4:3] and SEL_B SHALL equal IR[2:1]; both are registered outputs that hold their value in FETCH.
REQ-017: In EXEC and WB, ALU_OP SHALL be the decoded value: ADD 00, SUB 01, AND 10, OR 11; NOP, JMP, BRZ and HLT SHALL drive 01 (SUB) so that Z compares the operands.
REQ-018: WR_EN SHALL be 1 only in WB, and only for ADD/SUB/AND/OR, with WR_SEL = IR[4:3]; otherwise WR_EN = 0 and WR_SEL holds its value.
REQ-019: BRZ SHALL sample Z at the end of EXEC into a taken flag.
REQ-020: At the end of WB, PC SHALL become IR[3:0] for JMP or for taken BRZ; otherwise PC+1 modulo 16 (15 wraps to 0).
REQ-021: HLT decoded in DECODE SHALL move the FSM to HALTED at the end of the cycle.
REQ-022: In HALTED, HALT SHALL be 1, PC SHALL be frozen at the HLT address, WR_EN SHALL be 0, and the state SHALL be held until rst.
REQ-023: INSTR SHALL be ignored in every state except FETCH.
REQ-024: Z SHALL be ignored except in EXEC of a BRZ.

Reset
REQ-025: rst SHALL override every other event in the same cycle, mid-instruction included.
REQ-026: After rst the FSM SHALL be in FETCH, with PC = 0, IR = 0, SEL_A = SEL_B = WR_SEL = ALU_OP = 0, WR_EN = 0, HALT = 0 and the taken flag = 0.
REQ-027: A write in progress SHALL be suppressed: WR_EN = 0 in the cycle after rst is sampled.

Structure
REQ-028: Package ctrl_pkg SHALL hold the opcode constants, the 3-bit state encoding and the ALU_OP codes.
REQ-029: The PC SHALL be implemented in one sub-module, pc4, with inputs clk, rst, inc, load and D[3:0] and output Q[3:0]; load has priority over inc.
REQ-030: All remaining logic SHALL be in ctrl_seq; no latches and no combinational paths from INSTR to any output.

Verification
REQ-031: rst, then ROM[0] = ADD r1,r2 (8'b001_01_10_0) -> SEL_A = 01 and SEL_B = 10 from cycle 2; WR_EN = 1 with WR_SEL = 01 in cycle 4 only; PC = 1 from cycle 5.
REQ-032: JMP to 4'hA (8'b101_0_1010) at PC = 3 -> PC = A after WB; no WR_EN pulse.
REQ-033: BRZ to 4'h7 with Z = 1 in EXEC -> PC = 7; the same instruction with Z = 0 -> PC = PC+1; Z toggled outside EXEC has no effect.
REQ-034: 16 consecutive NOPs from PC = 0 -> PC wraps 15->0 and WR_EN stays 0 throughout.
REQ-035: HLT at PC = 5 -> HALT = 1 from the cycle after DECODE and PC stays at 5 for 20 cycles while INSTR is randomized; rst -> PC = 0, HALT = 0.
REQ-036: rst asserted in WB of an ADD -> WR_EN = 0 the following cycle, state FETCH, PC = 0.
